dfr_sequencer: RTL and testbench

- Sequences the virtual-node delay-line reservoir for one run of input samples.
- Per sample, steps through VIRTUAL_NODES node slots. Each slot forms masked input plus delayed feedback (res_dout, the same node from the previous sample), drives it on res_din and asserts res_en.
- Every written node value is emitted on a valid/ready state stream to the readout.
- Owns the input-mask table, reservoir clear, and run start/done control.

---
 rtl/dfr_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dfr_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_sequencer.sv
// ---------------------------------------------------------------------------
// dfr_sequencer
//   Sequences a virtual-node delay-line reservoir over one run of input
//   samples. For each accepted sample it visits VIRTUAL_NODES node slots. In
//   each slot it forms (sample * mask[node]) >>> FRAC_BITS plus the delayed
//   feedback from the reservoir tail, saturates the result, drives it to the
//   reservoir and publishes it on a valid/ready state stream.
//
// Optional feature (compile-time macro DFR_FB_SCALE_EN):
//   defined   : feedback = res_dout >>> fb_shift, with fb_shift captured when
//               a start is accepted and held for the whole run
//   undefined : feedback = res_dout, and the fb_shift port is ignored
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start, num_samples run start pulse and sample count (honoured in IDLE only)
//   mask_we/addr/data  mask table write port (honoured in IDLE only)
//   fb_shift           feedback attenuation shift (DFR_FB_SCALE_EN only)
//   in_valid/ready/data      input sample handshake
//   res_din/en/clr, res_dout reservoir interface (write value, shift, clear, tail)
//   out_valid/ready/data/node/last  state stream to the readout
//   busy, done         run status and one-cycle completion pulse
// ---------------------------------------------------------------------------
module dfr_sequencer #(
  parameter int VIRTUAL_NODES    = 10,
  parameter int DATA_WIDTH       = 32,
  parameter int MASK_WIDTH       = 16,
  parameter int FRAC_BITS        = 8,
  parameter int SAMPLE_CNT_WIDTH = 16,
  localparam int AW              = $clog2(VIRTUAL_NODES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [SAMPLE_CNT_WIDTH-1:0] num_samples,
  input  logic                        mask_we,
  input  logic [AW-1:0]               mask_addr,
  input  logic [MASK_WIDTH-1:0]       mask_data,
  input  logic [3:0]                  fb_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic [DATA_WIDTH-1:0]       res_din,
  output logic                        res_en,
  output logic                        res_clr,
  input  logic [DATA_WIDTH-1:0]       res_dout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [AW-1:0]               out_node,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  localparam int PW = DATA_WIDTH + MASK_WIDTH;
  localparam int SW = PW + 1;
  localparam logic [AW-1:0] LAST_NODE  = AW'(VIRTUAL_NODES - 1);
  localparam logic [AW:0]   NODE_COUNT = (AW + 1)'(VIRTUAL_NODES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_WAIT_IN = 3'd2,
    S_STEP    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t state, next_state;

  logic [MASK_WIDTH-1:0]       mask_tab [VIRTUAL_NODES];
  logic [DATA_WIDTH-1:0]       in_sample;
  logic [AW-1:0]               node_idx;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_cnt;
  logic [SAMPLE_CNT_WIDTH-1:0] sample_total;
  logic                        last_node;
  logic                        last_sample;
  logic                        fire;

  logic [MASK_WIDTH-1:0]        mask_sel;
  logic signed [PW-1:0]         sample_ext;
  logic signed [PW-1:0]         mask_ext;
  logic signed [PW-1:0]         prod_full;
  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH-1:0] fb_raw;
  logic signed [DATA_WIDTH-1:0] fb_val;
  logic signed [SW-1:0]         sum;
  logic [SW-DATA_WIDTH:0]       sum_upper;

`ifdef DFR_FB_SCALE_EN
  logic [3:0] fb_shift_q;
`else
  logic unused_fb_shift;
  assign unused_fb_shift = ^fb_shift;
`endif

  assign last_node   = (node_idx == LAST_NODE);
  assign last_sample = (sample_cnt == (sample_total - SAMPLE_CNT_WIDTH'(1'b1)));
  // A new node can be published when the output register is empty or being drained.
  assign fire        = !out_valid || out_ready;
  assign busy        = (state != S_IDLE);
  assign mask_sel    = mask_tab[node_idx];

  // Node arithmetic: scaled masked input plus feedback, saturated to DATA_WIDTH.
  always_comb begin
    sample_ext = {{MASK_WIDTH{in_sample[DATA_WIDTH-1]}}, in_sample};
    mask_ext   = {{DATA_WIDTH{mask_sel[MASK_WIDTH-1]}}, mask_sel};
    prod_full  = sample_ext * mask_ext;
    prod       = prod_full >>> FRAC_BITS;
`ifdef DFR_FB_SCALE_EN
    fb_raw     = $signed(res_dout) >>> fb_shift_q;
`else
    fb_raw     = $signed(res_dout);
`endif
    // The reservoir was just cleared, so the first sample carries no feedback.
    if (sample_cnt == '0) begin
      fb_val = '0;
    end else begin
      fb_val = fb_raw;
    end
    sum = {{(SW - PW){prod[PW-1]}}, prod}
        + {{(SW - DATA_WIDTH){fb_val[DATA_WIDTH-1]}}, fb_val};
    // All bits from the DATA_WIDTH sign position upward must agree to fit.
    sum_upper = sum[SW-1:DATA_WIDTH-1];
    if ((&sum_upper) || !(|sum_upper)) begin
      res_din = sum[DATA_WIDTH-1:0];
    end else if (sum[SW-1]) begin
      res_din = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      res_din = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded strobes.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    res_en     = 1'b0;
    res_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && (num_samples != '0)) begin
          next_state = S_CLEAR;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        res_clr    = 1'b1;
        next_state = S_WAIT_IN;
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = S_STEP;
        end else begin
          next_state = S_WAIT_IN;
        end
      end
      S_STEP: begin
        if (fire) begin
          res_en = 1'b1;
          if (last_node && last_sample) begin
            next_state = S_DRAIN;
          end else if (last_node) begin
            next_state = S_WAIT_IN;
          end else begin
            next_state = S_STEP;
          end
        end else begin
          next_state = S_STEP;
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          next_state = S_IDLE;
        end else begin
          next_state = S_DRAIN;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Mask table: writable only while idle, out-of-range addresses dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VIRTUAL_NODES; i++) begin
        mask_tab[i] <= '0;
      end
    end else if ((state == S_IDLE) && mask_we && ({1'b0, mask_addr} < NODE_COUNT)) begin
      mask_tab[mask_addr] <= mask_data;
    end
  end

  // Run control counters, sample capture and the registered output stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_sample    <= '0;
      node_idx     <= '0;
      sample_cnt   <= '0;
      sample_total <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_node     <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
`ifdef DFR_FB_SCALE_EN
      fb_shift_q   <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_samples == '0) begin
              done <= 1'b1;
            end else begin
              sample_total <= num_samples;
              sample_cnt   <= '0;
`ifdef DFR_FB_SCALE_EN
              fb_shift_q   <= fb_shift;
`endif
            end
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            in_sample <= in_data;
            node_idx  <= '0;
          end
        end
        S_STEP: begin
          if (fire) begin
            node_idx <= node_idx + AW'(1'b1);
            if (last_node) begin
              sample_cnt <= sample_cnt + SAMPLE_CNT_WIDTH'(1'b1);
            end
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            done <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase

      // A step refills the output register; otherwise acceptance empties it.
      if (res_en) begin
        out_data  <= res_din;
        out_node  <= node_idx;
        out_valid <= 1'b1;
        out_last  <= last_node && last_sample;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dfr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dfr_sequencer
//   Self-checking bench for dfr_sequencer (VIRTUAL_NODES=4, DATA_WIDTH=16,
//   MASK_WIDTH=8, FRAC_BITS=4). A delay-line reservoir is modelled around the
//   DUT; expected node values come from a per-node arithmetic model (previous
//   value of the same node as feedback, saturating add). Honours
//   DFR_FB_SCALE_EN in the model with fb_shift fixed at 1.
// ---------------------------------------------------------------------------
module tb_dfr_sequencer;
  localparam int VN  = 4;
  localparam int DW  = 16;
  localparam int MW  = 8;
  localparam int FB  = 4;
  localparam int SCW = 16;
  localparam int AW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [SCW-1:0] num_samples;
  logic           mask_we;
  logic [AW-1:0]  mask_addr;
  logic [MW-1:0]  mask_data;
  logic [3:0]     fb_shift;
  logic           in_valid, in_ready;
  logic [DW-1:0]  in_data;
  logic [DW-1:0]  res_din, res_dout;
  logic           res_en, res_clr;
  logic           out_valid, out_ready, out_last, busy, done;
  logic [DW-1:0]  out_data;
  logic [AW-1:0]  out_node;

  always #5 clk = ~clk;

  dfr_sequencer #(
    .VIRTUAL_NODES(VN), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .FRAC_BITS(FB), .SAMPLE_CNT_WIDTH(SCW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .mask_we(mask_we), .mask_addr(mask_addr), .mask_data(mask_data),
    .fb_shift(fb_shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .res_din(res_din), .res_en(res_en), .res_clr(res_clr),
    .res_dout(res_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_node(out_node), .out_last(out_last),
    .busy(busy), .done(done)
  );

  // Reservoir: VN-deep delay line, tail is the same node one sample earlier.
  logic [DW-1:0] res_line [VN];
  assign res_dout = res_line[VN-1];
  always @(posedge clk) begin
    if (res_clr) begin
      for (int i = 0; i < VN; i++) res_line[i] <= '0;
    end else if (res_en) begin
      res_line[0] <= res_din;
      for (int i = 1; i < VN; i++) res_line[i] <= res_line[i-1];
    end
  end

  typedef struct { int data; int node; bit last; } exp_t;
  exp_t exp_q[$];
  int   mask_m [VN];
  int   smp [$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: node k of sample s = sat(floor(s*mask[k]/2^FB) + prev[k]).
  function automatic void build_exp(input int n);
    longint prev [VN];
    longint p, f, sm;
    for (int k = 0; k < VN; k++) prev[k] = 0;
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < VN; k++) begin
        p = (longint'(smp[s]) * longint'(mask_m[k])) >>> FB;
        f = (s == 0) ? 64'sd0 : prev[k];
`ifdef DFR_FB_SCALE_EN
        f = f >>> 1;
`endif
        sm = p + f;
        if (sm > 32767) sm = 32767;
        else if (sm < -32768) sm = -32768;
        prev[k] = sm;
        exp_q.push_back('{int'(sm), k, (s == n - 1) && (k == VN - 1)});
      end
    end
  endfunction

  task automatic write_masks();
    for (int k = 0; k < VN; k++) begin
      mask_we = 1'b1; mask_addr = AW'(k); mask_data = MW'(mask_m[k]);
      @(posedge clk); #1;
    end
    mask_we = 1'b0;
  endtask

  // mode 0: out_ready=1, 1: random backpressure, 2: 3-cycle stall + busy mask write
  task automatic do_run(input string tag, input int n, input int mode);
    int si, cyc, clr_cnt;
    bit got_done;
    exp_t e;
    exp_q.delete();
    build_exp(n);
    start = 1'b1; num_samples = SCW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    si = 0; cyc = 0; clr_cnt = 0; got_done = 1'b0;
    while (!got_done && cyc < 2000) begin
      in_valid = (si < n);
      in_data  = (si < n) ? DW'(smp[si]) : '0;
      if (mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) out_ready = !(cyc >= 4 && cyc < 7);
      else                out_ready = 1'b1;
      if (mode == 2) begin
        mask_we = 1'b1; mask_addr = '0; mask_data = 8'sd99;
      end
      @(negedge clk);
      if (res_clr) clr_cnt++;
      if (out_valid && !out_ready) chk({tag, "_stall_en"}, res_en, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_out"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_data"}, $signed(out_data), e.data);
          chk({tag, "_node"}, out_node, e.node);
          chk({tag, "_last"}, out_last, e.last);
        end
      end
      if (in_valid && in_ready) si++;
      if (done) begin
        got_done = 1'b1;
        mask_we  = 1'b0;
        chk({tag, "_busy_at_done"}, busy, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1; mask_we = 1'b0;
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
    chk({tag, "_clr_cnt"}, clr_cnt, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_node"}, out_node, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res_en"}, res_en, 0);
    chk({tag, "_res_clr"}, res_clr, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_res_din"}, res_din, 0);
  endtask

  initial begin
    int n;
    bit saw_en;
    rst = 1'b1; start = 1'b0; num_samples = '0; mask_we = 1'b0;
    mask_addr = '0; mask_data = '0; fb_shift = 4'd1; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    mask_m = '{16, 32, -16, 8};
    write_masks();

    // Zero-length run: done next cycle, no clear, stays idle.
    start = 1'b1; num_samples = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_clr", res_clr, 0);
    @(posedge clk); #1;
    chk("zero_done_drop", done, 0);

    smp = '{100};               do_run("single", 1, 0);
    smp = '{100, 10};           do_run("two", 2, 0);
    smp = '{32767, -32768};     do_run("sat", 2, 0);
    smp = '{100, 10};           do_run("stall", 2, 2);
    smp = '{100, 10};           do_run("after_busy_wr", 2, 0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < VN; k++) mask_m[k] = int'($urandom_range(0, 255)) - 128;
      write_masks();
      n = int'($urandom_range(1, 5));
      smp.delete();
      for (int s = 0; s < n; s++) begin
        if (s == 1)      smp.push_back(32767);
        else if (s == 2) smp.push_back(-32768);
        else             smp.push_back(int'($urandom_range(0, 65535)) - 32768);
      end
      do_run("rand", n, 1);
    end

    // Reset in the middle of a step sequence.
    mask_m = '{16, 32, -16, 8};
    write_masks();
    start = 1'b1; num_samples = SCW'(2);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'sd100;
    saw_en = 1'b0;
    for (int c = 0; c < 20 && !saw_en; c++) begin
      @(negedge clk);
      if (res_en) saw_en = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("midrst_reach_step", saw_en, 1);
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < VN; k++) mask_m[k] = 0;
    smp = '{1234};
    do_run("mask_cleared", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
